// File: rtl/imm_decode_stage.sv
// Immediate decode stage: classifies the immediate format, sign-extends it, and precomputes pc+imm.
// Output appears one cycle after accept; a 2-entry skid buffer keeps in_ready registered at full throughput.
module imm_decode_stage #(
  parameter int XLEN     = 32,
  parameter bit RV64_OPS = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  localparam bit RV64_EN = RV64_OPS && (XLEN == 64);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } entry_t;

  entry_t dec, main_q, skid_q;
  logic   main_vld, skid_vld;
  logic   accept, drain;
  logic [31:0] imm32;
  fmt_e        fmt;
  logic        illegal;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  // Every format is first built as a 32-bit signed value, then widened by sext32.
  always_comb begin
    imm32   = '0;
    fmt     = FMT_R;
    illegal = 1'b0;
    case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111: begin
        fmt   = FMT_I;
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0011011: begin
        if (RV64_EN) begin
          fmt   = FMT_I;
          imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        end else begin
          illegal = 1'b1;
        end
      end
      7'b0100011: begin
        fmt   = FMT_S;
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        fmt   = FMT_B;
        imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        fmt   = FMT_U;
        imm32 = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        fmt   = FMT_J;
        imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b0110011: fmt = FMT_R;
      7'b0111011: illegal = !RV64_EN;
      default:    illegal = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) begin
      illegal = 1'b1;
      fmt     = FMT_R;
      imm32   = '0;
    end
  end

  always_comb begin
    dec         = '0;
    dec.imm     = sext32(imm32);
    dec.fmt     = fmt;
    dec.pc      = in_pc;
    dec.target  = in_pc + dec.imm;
    dec.illegal = illegal;
  end

  assign in_ready = !skid_vld;
  assign accept   = in_valid && in_ready;
  assign drain    = main_vld && out_ready;

  // No accept is possible while skid is full, so that branch only has to refill main.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (skid_vld) begin
      if (drain) begin
        main_q   <= skid_q;
        skid_vld <= 1'b0;
      end
    end else if (accept) begin
      if (!main_vld || drain) begin
        main_q   <= dec;
        main_vld <= 1'b1;
      end else begin
        skid_q   <= dec;
        skid_vld <= 1'b1;
      end
    end else if (drain) begin
      main_vld <= 1'b0;
    end
  end

  assign out_valid   = main_vld;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_target  = main_q.target;
  assign out_pc      = main_q.pc;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench: a 32-bit and a 64-bit (RV64_OPS) instance share stimulus; each has its own expected queue.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        rdy_a, vld_a, ill_a;
  logic [31:0] imm_a, tgt_a, pc_a;
  logic [2:0]  fmt_a;
  logic        rdy_b, vld_b, ill_b;
  logic [63:0] imm_b, tgt_b, pc_b;
  logic [2:0]  fmt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .RV64_OPS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .in_instr(in_instr),
    .in_pc(in_pc[31:0]), .out_valid(vld_a), .out_ready(out_ready), .out_imm(imm_a),
    .out_fmt(fmt_a), .out_target(tgt_a), .out_pc(pc_a), .out_illegal(ill_a));

  imm_decode_stage #(.XLEN(64), .RV64_OPS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .in_instr(in_instr),
    .in_pc(in_pc), .out_valid(vld_b), .out_ready(out_ready), .out_imm(imm_b),
    .out_fmt(fmt_b), .out_target(tgt_b), .out_pc(pc_b), .out_illegal(ill_b));

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [63:0] tgt;
    logic [63:0] pc;
    logic        ill;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: immediates from arithmetic on the instruction fields.
  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc,
                                 input bit is64);
    exp_t        e;
    longint      imm;
    int          f;
    logic [63:0] mask;
    mask = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67, 7'h73, 7'h0F: f = 1;
      7'h1B: f = is64 ? 1 : -1;
      7'h23: f = 2;
      7'h63: f = 3;
      7'h37, 7'h17: f = 4;
      7'h6F: f = 5;
      7'h33: f = 0;
      7'h3B: f = is64 ? 0 : -1;
      default: f = -1;
    endcase
    if (ins[1:0] != 2'b11) f = -1;
    case (f)
      1: imm = longint'($signed(ins) >>> 20);
      2: imm = longint'(($signed(ins) >>> 25) * 32) + longint'(ins[11:7]);
      3: imm = (ins[31] ? -64'sd4096 : 64'sd0) + longint'(ins[7]) * 2048
               + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
      4: imm = longint'($signed(ins & 32'hFFFF_F000));
      5: imm = (ins[31] ? -64'sd1048576 : 64'sd0) + longint'(ins[19:12]) * 4096
               + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
      default: imm = 0;
    endcase
    e.imm = 64'(imm) & mask;
    e.fmt = (f < 0) ? 3'd0 : 3'(f);
    e.pc  = pc & mask;
    e.tgt = (pc + 64'(imm)) & mask;
    e.ill = (f < 0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && vld_a) begin
      if (qa.size() == 0) begin
        check("a_spurious_valid", 64'(vld_a), 64'd0);
      end else begin
        check("a_imm", 64'(imm_a), qa[0].imm);
        check("a_fmt", 64'(fmt_a), 64'(qa[0].fmt));
        check("a_target", 64'(tgt_a), qa[0].tgt);
        check("a_pc", 64'(pc_a), qa[0].pc);
        check("a_illegal", 64'(ill_a), 64'(qa[0].ill));
        if (out_ready) void'(qa.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && vld_b) begin
      if (qb.size() == 0) begin
        check("b_spurious_valid", 64'(vld_b), 64'd0);
      end else begin
        check("b_imm", imm_b, qb[0].imm);
        check("b_fmt", 64'(fmt_b), 64'(qb[0].fmt));
        check("b_target", tgt_b, qb[0].tgt);
        check("b_pc", pc_b, qb[0].pc);
        check("b_illegal", 64'(ill_b), 64'(qb[0].ill));
        if (out_ready) void'(qb.pop_front());
      end
    end
  end

  // Presents one instruction until accepted; waits = cycles spent with in_ready low.
  task automatic send(input logic [31:0] ins, input logic [63:0] pc, output int waits);
    bit done = 0;
    waits    = 0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (rdy_a !== rdy_b) check("ready_match", 64'(rdy_b), 64'(rdy_a));
      if (rdy_a) begin
        qa.push_back(model(ins, pc, 1'b0));
        qb.push_back(model(ins, pc, 1'b1));
        done = 1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain_all();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && (qa.size() != 0 || qb.size() != 0); i++) @(posedge clk);
    #1;
    check("drain_a_left", 64'(qa.size()), 64'd0);
    check("drain_b_left", 64'(qb.size()), 64'd0);
  endtask

  logic [6:0] ops [14] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h0F, 7'h1B, 7'h23,
                           7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h0B};
  bit rand_done;

  initial begin
    int w;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_instr = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(rdy_a), 64'd1);
    check("rst_out_valid", 64'(vld_a), 64'd0);
    rst = 1'b0;

    // Streaming ADDI with no back-pressure: in_ready must never drop.
    for (int i = 0; i < 4; i++) begin
      send(32'hFFF0_0093, 64'h100, w);
      check("stream_wait", 64'(w), 64'd0);
    end
    send(32'hFF9F_F06F, 64'h200, w);
    send(32'h7E00_0FE3, 64'hFFFF_FFF0, w);
    send(32'h8000_00B7, 64'h0, w);
    send(32'h0000_000B, 64'h40, w);
    send(32'h0000_0093, 64'h44, w);
    send(32'h0000_003B, 64'h48, w);
    send(32'h8000_001B, 64'h4C, w);
    drain_all();

    // Back-pressure: A held in main, B in skid, C and D stall then flow in order.
    out_ready = 1'b0;
    send(32'h0040_0093, 64'h1000, w);
    send(32'h00C1_2023, 64'h1004, w);
    @(negedge clk);
    check("bp_in_ready", 64'(rdy_a), 64'd0);
    check("bp_out_valid", 64'(vld_a), 64'd1);
    @(posedge clk);
    #1;
    fork
      begin
        send(32'h0000_0463, 64'h1008, w);
        send(32'h0080_006F, 64'h100C, w);
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain_all();

    // Reset with main and skid full: nothing survives.
    out_ready = 1'b0;
    send(32'h1234_5037, 64'h2000, w);
    send(32'hFFF0_0113, 64'h2004, w);
    rst = 1'b1;
    qa.delete();
    qb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 64'(vld_a | vld_b), 64'd0);
    check("post_rst_ready", 64'(rdy_a & rdy_b), 64'd1);
    check("post_rst_imm", imm_b | 64'(imm_a), 64'd0);
    check("post_rst_fmt", 64'(fmt_a | fmt_b), 64'd0);
    check("post_rst_target", tgt_b | 64'(tgt_a), 64'd0);
    check("post_rst_pc", pc_b | 64'(pc_a), 64'd0);
    check("post_rst_illegal", 64'(ill_a | ill_b), 64'd0);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Random instructions under random back-pressure.
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          logic [31:0] ins;
          logic [63:0] pc;
          ins = $urandom;
          if ($urandom_range(0, 7) != 0) ins[6:0] = ops[$urandom_range(0, 13)];
          pc  = {$urandom, $urandom};
          send(ins, pc, w);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
